// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential multiplier and the output select stage.
// Holds the default operand width, the function-code constants and the
// multiplier FSM state encoding.
package seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Function codes
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SRL   = 6'b000010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result bundle of the sequential multiplier.
//   dataA, dataB, Signal : operands and function code (driven by master)
//   HiOut, LoOut         : last completed product halves (driven by slave)
//   busy, done           : multiply in progress / one-cycle completion pulse
interface seq_multiplier_if #(
    parameter int WIDTH = seq_multiplier_pkg::DEFAULT_WIDTH
);
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;
    logic             busy;
    logic             done;

    modport master (
        output dataA, dataB, Signal,
        input  HiOut, LoOut, busy, done
    );

    modport slave (
        input  dataA, dataB, Signal,
        output HiOut, LoOut, busy, done
    );
endinterface

// File: rtl/seq_multiplier_hilo_reg.sv
// hilo_reg: the Hi/Lo result register pair.
//   clk, reset : clock, synchronous active-high reset
//   we         : write enable; loads din into {hi, lo}
//   din        : 2*WIDTH product, upper half goes to hi
//   hi, lo     : registered halves
module hilo_reg #(
    parameter int WIDTH = seq_multiplier_pkg::DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [2*WIDTH-1:0] din,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (we) begin
            hi <= din[2*WIDTH-1:WIDTH];
            lo <= din[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned WIDTH x WIDTH shift-add multiplier, one step per
// clock, WIDTH steps per operation.
//   clk, reset : clock, synchronous active-high reset
//   bus        : seq_multiplier_if slave (operands, function code, Hi/Lo,
//                busy, done)
// A start is accepted in IDLE or DONE when Signal equals OP_MULTU. Hi/Lo are
// only written on the edge that completes the last step, so partial
// products never appear on the outputs.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int         WIDTH    = DEFAULT_WIDTH,
    parameter logic [5:0] OP_MULTU = 6'b011001
) (
    input  logic clk,
    input  logic reset,
    seq_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    mul_state_t       state;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH:0] product;     // carry bit + 2*WIDTH
    logic [CW-1:0]    counter;
    logic [2*WIDTH:0] product_step;
    logic [WIDTH:0]   upper_sum;
    logic             last_step;
    logic             start;

    // One shift-add step on the current product.
    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise a latch is inferred.
    always_comb begin
        upper_sum = {1'b0, product[2*WIDTH-1:WIDTH]};
        if (product[0]) begin
            upper_sum = upper_sum + {1'b0, mcand};
        end
        product_step = {1'b0, upper_sum, product[WIDTH-1:1]};
    end

    assign last_step = (state == S_RUN) && (counter == CW'(WIDTH - 1));
    assign start     = (state != S_RUN) && (bus.Signal == OP_MULTU);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            mcand   <= '0;
            product <= '0;
            counter <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mcand   <= bus.dataA;
                        product <= {{(WIDTH + 1){1'b0}}, bus.dataB};
                        counter <= '0;
                        state   <= S_RUN;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_RUN: begin
                    product <= product_step;
                    counter <= counter + 1'b1;
                    if (last_step) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    hilo_reg #(.WIDTH(WIDTH)) u_hilo (
        .clk   (clk),
        .reset (reset),
        .we    (last_step),
        .din   (product_step[2*WIDTH-1:0]),
        .hi    (bus.HiOut),
        .lo    (bus.LoOut)
    );

    assign bus.busy = (state == S_RUN);
    assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH = 32).
module tb_seq_multiplier;
    import seq_multiplier_pkg::*;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W), .OP_MULTU(FN_MULTU)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present a start at the next edge (E0); return #1 after E0 with the
    // function code moved away and the operands scrambled.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.dataA  = a;
        bus.dataB  = b;
        bus.Signal = FN_MULTU;
        @(posedge clk);
        #1;
        bus.Signal = FN_MFHI;
        bus.dataA  = $urandom;
        bus.dataB  = $urandom;
    endtask

    // Sample busy/done now and after each of the next n-1 edges, ending #1
    // after the n-th edge.
    task automatic run_edges(input int n, output int busy_cnt, output int done_cnt);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_result(input string tag, input logic [63:0] exp);
        check({tag, "_hilo"}, {bus.HiOut, bus.LoOut}, exp);
    endtask

    initial begin
        int bc, dc, bc2, dc2;
        logic [W-1:0] hi_keep, lo_keep;
        logic [5:0] other_codes [8];
        total = 0;
        bad   = 0;
        other_codes = '{FN_MFHI, FN_MFLO, FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL};

        bus.dataA  = '0;
        bus.dataB  = '0;
        bus.Signal = FN_MFLO;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check_result("rst", 64'd0);

        // 3 x 5
        issue(32'd3, 32'd5);
        run_edges(33, bc, dc);
        check("t1_busy_cycles", 64'(bc), 64'd32);
        check("t1_done_pulses", 64'(dc), 64'd1);
        check("t1_busy_end", 64'(bus.busy), 64'd0);
        check("t1_done_end", 64'(bus.done), 64'd0);
        check_result("t1", 64'd15);

        // 0 x 12345678
        issue(32'd0, 32'h12345678);
        run_edges(33, bc, dc);
        check("t3_busy_cycles", 64'(bc), 64'd32);
        check("t3_done_pulses", 64'(dc), 64'd1);
        check_result("t3", 64'd0);

        // FFFFFFFF x FFFFFFFF, with Hi/Lo held during RUN
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_edges(20, bc, dc);
        check_result("t2_hold_in_run", 64'd0);
        run_edges(13, bc2, dc2);
        check("t2_busy_cycles", 64'(bc + bc2), 64'd32);
        check("t2_done_pulses", 64'(dc + dc2), 64'd1);
        check_result("t2", 64'hFFFF_FFFE_0000_0001);

        // Non-multiply codes leave everything alone
        hi_keep = bus.HiOut;
        lo_keep = bus.LoOut;
        foreach (other_codes[i]) begin
            @(negedge clk);
            bus.Signal = other_codes[i];
            bus.dataA  = $urandom;
            bus.dataB  = $urandom;
            @(posedge clk);
            #1;
            check("other_busy", 64'(bus.busy), 64'd0);
        end
        check("other_hilo", {bus.HiOut, bus.LoOut}, {hi_keep, lo_keep});
        bus.Signal = FN_MFHI;

        // Reset in RUN at counter=10
        issue(32'd5, 32'd6);
        run_edges(10, bc, dc);
        check("t4_busy_before_rst", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t4_busy", 64'(bus.busy), 64'd0);
        check("t4_done", 64'(bus.done), 64'd0);
        check_result("t4", 64'd0);
        run_edges(40, bc, dc);
        check("t4_busy_after", 64'(bc), 64'd0);
        check("t4_done_after", 64'(dc), 64'd0);
        check_result("t4_after", 64'd0);

        // 7 x 9 with a 2 x 2 re-issue at counter=5
        issue(32'd7, 32'd9);
        run_edges(5, bc, dc);
        bus.Signal = FN_MULTU;
        bus.dataA  = 32'd2;
        bus.dataB  = 32'd2;
        @(posedge clk);
        #1;
        bus.Signal = FN_MFLO;
        check("t5_still_busy", 64'(bus.busy), 64'd1);
        run_edges(27, bc2, dc2);
        check("t5_done_pulses", 64'(dc + dc2), 64'd1);
        check_result("t5", 64'd63);
        run_edges(35, bc, dc);
        check("t5_no_restart_busy", 64'(bc), 64'd0);
        check("t5_no_restart_done", 64'(dc), 64'd0);

        // 4 x 4 then 6 x 7 held during the DONE cycle
        issue(32'd4, 32'd4);
        run_edges(32, bc, dc);
        check("t6_in_done", 64'(bus.done), 64'd1);
        bus.Signal = FN_MULTU;
        bus.dataA  = 32'd6;
        bus.dataB  = 32'd7;
        @(posedge clk);
        #1;
        bus.Signal = FN_SRL;
        bus.dataA  = 32'd100;
        bus.dataB  = 32'd100;
        check("t6_accepted", 64'(bus.busy), 64'd1);
        check("t6_done_low", 64'(bus.done), 64'd0);
        check_result("t6_first", 64'd16);
        run_edges(33, bc, dc);
        check("t6_busy_cycles", 64'(bc), 64'd32);
        check("t6_done_pulses", 64'(dc), 64'd1);
        check_result("t6_second", 64'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
